// File: rtl/iob_axis_word_unpack.sv
// -----------------------------------------------------------------------------
// iob_axis_word_unpack
//
// Purpose:
//   Takes DATA_W-wide words from the AXI-stream input peripheral's system-stream
//   side and re-emits them as a TDATA_W-wide AXI stream. Each word carries
//   R = DATA_W/TDATA_W beats, lane 0 in the LSBs. The frame length (in beats)
//   is taken from len_i when the first word of a frame is accepted. tlast is
//   asserted on the final beat. Lanes of the final word beyond the frame end
//   are padding inserted upstream and are dropped, which restores the frame.
//
// Ports:
//   clk_i         clock, single domain
//   rst_i         synchronous, active-high reset
//   en_i          enables acceptance of new input words (a held word always drains)
//   len_i         frame length in TDATA_W beats, captured at the first word
//   in_tvalid_i   input word valid
//   in_tdata_i    input word, lane p at bits [p*TDATA_W +: TDATA_W]
//   in_tready_o   input word ready
//   out_tvalid_o  output beat valid
//   out_tdata_o   output beat data
//   out_tlast_o   last beat of the frame
//   out_tready_i  output beat ready
//   busy_o        a frame is in progress
//   done_o        one-cycle pulse the cycle after the tlast handshake
//   beat_count_o  beats emitted in the current or most recent frame
// -----------------------------------------------------------------------------
module iob_axis_word_unpack #(
    parameter int DATA_W  = 32,
    parameter int TDATA_W = 8,
    parameter int LEN_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               in_tvalid_i,
    input  logic [DATA_W-1:0]  in_tdata_i,
    output logic               in_tready_o,
    output logic               out_tvalid_o,
    output logic [TDATA_W-1:0] out_tdata_o,
    output logic               out_tlast_o,
    input  logic               out_tready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [LEN_W-1:0]   beat_count_o
);

    localparam int R  = DATA_W / TDATA_W;
    localparam int LW = $clog2(R);
    localparam logic [LW-1:0] LANE_LAST = LW'(R - 1);

    // Lane indexing relies on R being a power of two so that lane_idx wraps
    // naturally from R-1 to 0.
    generate
        if ((DATA_W % TDATA_W) != 0 || R < 2 || (R & (R - 1)) != 0) begin : g_bad_params
            $error("iob_axis_word_unpack: DATA_W/TDATA_W must be a power of two >= 2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic [LW-1:0]     lane_idx;
    logic [LEN_W-1:0]  frame_len;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  beat_count;
    logic              busy;
    logic              done;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic hs_out;
    logic hs_in;
    logic at_last_lane;
    logic is_last_beat;
    logic word_drained;
    logic frame_end;
    logic new_frame;
    logic len_ok;

    assign hs_out       = hold_valid & out_tready_i;
    assign at_last_lane = (lane_idx == LANE_LAST);
    assign is_last_beat = (beat_cnt == (frame_len - LEN_W'(1)));

    assign out_tvalid_o = hold_valid;
    assign out_tlast_o  = hold_valid & is_last_beat;

    // The held word is finished when its final lane leaves, or earlier when
    // the frame ends and the remaining lanes are padding.
    assign word_drained = hs_out & (at_last_lane | out_tlast_o);

    // A zero length can never produce a tlast, so no frame may start with it.
    assign len_ok = (len_i != '0);

    // Combinational from out_tready_i so the next word can load in the same
    // cycle the current one drains (no bubble between words or frames).
    assign in_tready_o = en_i & len_ok & (~hold_valid | word_drained);
    assign hs_in       = in_tvalid_i & in_tready_o;

    assign frame_end = hs_out & out_tlast_o;
    // A word accepted while idle, or in the same cycle the previous frame
    // ends, opens a new frame; otherwise it continues the current one.
    assign new_frame = hs_in & (~busy | frame_end);

    // -------------------------------------------------------------------------
    // Lane select
    // -------------------------------------------------------------------------
    always_comb begin
        out_tdata_o = hold[TDATA_W-1:0];
        for (int p = 0; p < R; p++) begin
            if (lane_idx == LW'(p)) begin
                out_tdata_o = hold[p*TDATA_W +: TDATA_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word holding register and lane pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            lane_idx   <= '0;
        end else begin
            if (frame_end) begin
                // Remaining lanes are padding: discard the word.
                hold_valid <= 1'b0;
            end else if (hs_out) begin
                lane_idx <= lane_idx + 1'b1;
                if (at_last_lane) begin
                    hold_valid <= 1'b0;
                end
            end
            // A new word takes priority over the drain above.
            if (hs_in) begin
                hold       <= in_tdata_i;
                hold_valid <= 1'b1;
                lane_idx   <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame tracking: length, beat counters, busy and done
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_len  <= '0;
            beat_cnt   <= '0;
            beat_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (frame_end) begin
                busy       <= 1'b0;
                done       <= 1'b1;
                beat_count <= frame_len;
            end else if (hs_out) begin
                beat_cnt   <= beat_cnt + 1'b1;
                beat_count <= beat_count + 1'b1;
            end
            // New-frame setup overrides the frame-end bookkeeping above.
            if (new_frame) begin
                frame_len  <= len_i;
                beat_cnt   <= '0;
                beat_count <= '0;
                busy       <= 1'b1;
            end
        end
    end

    assign busy_o       = busy;
    assign done_o       = done;
    assign beat_count_o = beat_count;

endmodule

// File: tb/tb_iob_axis_word_unpack.sv
`timescale 1ns/1ps
module tb_iob_axis_word_unpack;

    localparam int DATA_W  = 32;
    localparam int TDATA_W = 8;
    localparam int LEN_W   = 16;
    localparam int R       = DATA_W / TDATA_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [LEN_W-1:0]   len;
    logic               in_tvalid;
    logic [DATA_W-1:0]  in_tdata;
    logic               in_tready;
    logic               out_tvalid;
    logic [TDATA_W-1:0] out_tdata;
    logic               out_tlast;
    logic               out_tready;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   beat_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_axis_word_unpack #(
        .DATA_W (DATA_W),
        .TDATA_W(TDATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .len_i       (len),
        .in_tvalid_i (in_tvalid),
        .in_tdata_i  (in_tdata),
        .in_tready_o (in_tready),
        .out_tvalid_o(out_tvalid),
        .out_tdata_o (out_tdata),
        .out_tlast_o (out_tlast),
        .out_tready_i(out_tready),
        .busy_o      (busy),
        .done_o      (done),
        .beat_count_o(beat_count)
    );

    // Stimulus words waiting to be offered, with the frame length to present.
    logic [DATA_W-1:0]  in_words[$];
    logic [LEN_W-1:0]   in_lens[$];
    // Reference beat stream and observed beat stream.
    logic [TDATA_W-1:0] exp_data[$];
    logic               exp_last[$];
    logic [TDATA_W-1:0] obs_data[$];
    logic               obs_last[$];
    // Explicit words for the next frame (random if empty).
    logic [DATA_W-1:0]  fw[$];

    int n_cycles, stall_err, done_cnt, first_hs, last_hs, tl_valid, tl_rdy;

    // Reference model: a frame of flen beats is the first flen lanes of its
    // ceil(flen/R) words, in order, with tlast on the final one.
    task automatic add_frame(input int flen);
        logic [DATA_W-1:0] ws[$];
        logic [DATA_W-1:0] w;
        int nw;
        nw = (flen + R - 1) / R;
        for (int i = 0; i < nw; i++) begin
            if (fw.size() > 0) begin
                w = fw.pop_front();
            end else begin
                w = $urandom();
            end
            ws.push_back(w);
            in_words.push_back(w);
            in_lens.push_back(LEN_W'(flen));
        end
        for (int b = 0; b < flen; b++) begin
            w = ws[b / R];
            exp_data.push_back(w[(b % R) * TDATA_W +: TDATA_W]);
            exp_last.push_back(b == flen - 1);
        end
        fw.delete();
    endtask

    task automatic clear_queues();
        in_words.delete();
        in_lens.delete();
        exp_data.delete();
        exp_last.delete();
        obs_data.delete();
        obs_last.delete();
        fw.delete();
    endtask

    task automatic drive_inputs(input int rdy_pct, input int valid_pct, input int en_pct);
        out_tready = ($urandom_range(0, 99) < rdy_pct);
        en         = ($urandom_range(0, 99) < en_pct);
        if (in_words.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            in_tvalid = 1'b1;
            in_tdata  = in_words[0];
            len       = in_lens[0];
        end else begin
            in_tvalid = 1'b0;
            in_tdata  = $urandom();
            len       = '0;
        end
    endtask

    // Runs the stream until all reference beats have been observed or the
    // cycle budget runs out; records beats and handshake statistics.
    task automatic run_stream(input int rdy_pct, input int valid_pct, input int en_pct,
                              input int budget);
        int target;
        logic [TDATA_W-1:0] hd;
        logic hl;
        logic stalled;
        target    = exp_data.size();
        stalled   = 1'b0;
        hd        = '0;
        hl        = 1'b0;
        n_cycles  = 0;
        stall_err = 0;
        done_cnt  = 0;
        first_hs  = -1;
        last_hs   = -1;
        tl_valid  = 0;
        tl_rdy    = 0;
        obs_data.delete();
        obs_last.delete();
        drive_inputs(rdy_pct, valid_pct, en_pct);
        while (obs_data.size() < target && n_cycles < budget) begin
            @(negedge clk);
            if (stalled && (out_tvalid !== 1'b1 || out_tdata !== hd || out_tlast !== hl))
                stall_err++;
            if (done === 1'b1) done_cnt++;
            if (out_tvalid === 1'b1 && out_tready) begin
                obs_data.push_back(out_tdata);
                obs_last.push_back(out_tlast);
                if (first_hs < 0) first_hs = n_cycles;
                last_hs = n_cycles;
                if (out_tlast === 1'b1 && in_tvalid) begin
                    tl_valid++;
                    if (in_tready === 1'b1) tl_rdy++;
                end
                stalled = 1'b0;
            end else if (out_tvalid === 1'b1) begin
                stalled = 1'b1;
                hd      = out_tdata;
                hl      = out_tlast;
            end else begin
                stalled = 1'b0;
            end
            if (in_tvalid && in_tready === 1'b1) begin
                in_words.delete(0);
                in_lens.delete(0);
            end
            @(posedge clk);
            #1;
            n_cycles++;
            drive_inputs(rdy_pct, valid_pct, en_pct);
        end
        in_tvalid  = 1'b0;
        len        = '0;
        en         = 1'b1;
        out_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; len = '0; in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", out_tvalid); end
        total++; if (out_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", out_tdata); end
        total++; if (out_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", out_tlast); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (beat_count !== '0) begin bad++; $display("FAIL reset_beat_count got=%0d want=0", beat_count); end
        total++; if (in_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", in_tready); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_words();
        clear_queues();
        fw.push_back(32'h44332211);
        fw.push_back(32'h88776655);
        add_frame(8);
        run_stream(100, 100, 100, 200);
        total++; if (obs_data.size() !== exp_data.size()) begin bad++; $display("FAIL s1_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL s1_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        total++; if (last_hs - first_hs + 1 !== 8) begin bad++; $display("FAIL s1_bubbles span got=%0d want=8", last_hs - first_hs + 1); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL s1_done got=%0d want=1", done_cnt); end
        total++; if (beat_count !== 16'd8) begin bad++; $display("FAIL s1_beat_count got=%0d want=8", beat_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL s1_busy got=%b want=0", busy); end
    endtask

    task automatic test_padding();
        clear_queues();
        fw.push_back(32'h44332211);
        fw.push_back(32'h00000055);
        add_frame(5);
        run_stream(100, 100, 100, 200);
        total++; if (obs_data.size() !== 5) begin bad++; $display("FAIL s2_count got=%0d want=5", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL s2_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL s2_padding_emitted tvalid got=%b want=0", out_tvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL s2_busy got=%b want=0", busy); end
        total++; if (beat_count !== 16'd5) begin bad++; $display("FAIL s2_beat_count got=%0d want=5", beat_count); end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int f = 0; f < 4; f++) add_frame(4);
        run_stream(100, 100, 100, 300);
        total++; if (obs_data.size() !== 16) begin bad++; $display("FAIL s3_count got=%0d want=16", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL s3_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        total++; if (tl_rdy !== 3 || tl_valid !== 3) begin bad++; $display("FAIL s3_tready_at_tlast got=%0d/%0d want=3/3", tl_rdy, tl_valid); end
        total++; if (last_hs - first_hs + 1 !== 16) begin bad++; $display("FAIL s3_bubbles span got=%0d want=16", last_hs - first_hs + 1); end
        total++; if (done_cnt !== 4) begin bad++; $display("FAIL s3_done got=%0d want=4", done_cnt); end
    endtask

    task automatic test_stall();
        clear_queues();
        fw.push_back(32'h44332211);
        fw.push_back(32'h88776655);
        add_frame(8);
        run_stream(50, 100, 100, 400);
        total++; if (obs_data.size() !== 8) begin bad++; $display("FAIL s4_count got=%0d want=8", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL s4_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL s4_stall_stable errors got=%0d want=0", stall_err); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL s4_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_len_zero();
        en = 1'b1; len = '0; in_tvalid = 1'b1; in_tdata = 32'hCAFEF00D; out_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (in_tready !== 1'b0 || out_tvalid !== 1'b0) begin
                bad++; $display("FAIL s5_len0 cyc%0d got tready=%b tvalid=%b want 0/0", c, in_tready, out_tvalid);
            end
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_queues();
        en = 1'b1; in_tvalid = 1'b1; in_tdata = 32'h44332211; len = 16'd8; out_tready = 1'b1;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (beat_count !== 16'd3) begin bad++; $display("FAIL s6_pre_count got=%0d want=3", beat_count); end
        total++; if (out_tdata !== 8'h44) begin bad++; $display("FAIL s6_pre_data got=%h want=44", out_tdata); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL s6_tvalid got=%b want=0", out_tvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL s6_busy got=%b want=0", busy); end
        total++; if (beat_count !== '0) begin bad++; $display("FAIL s6_beat_count got=%0d want=0", beat_count); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL s6_done got=%b want=0", done); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL s6_done_late got=%b want=0", done); end
        fw.push_back(32'hDDCCBBAA);
        add_frame(4);
        run_stream(100, 100, 100, 100);
        total++; if (obs_data.size() !== 4) begin bad++; $display("FAIL s6_count got=%0d want=4", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL s6_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        int nf;
        int lastlen;
        clear_queues();
        nf = 8;
        lastlen = 0;
        for (int f = 0; f < nf; f++) begin
            lastlen = $urandom_range(1, 13);
            add_frame(lastlen);
        end
        run_stream(60, 70, 80, 3000);
        total++; if (obs_data.size() !== exp_data.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                bad++; $display("FAIL rnd_beat%0d got=%h/%b want=%h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
            end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL rnd_stall_stable errors got=%0d want=0", stall_err); end
        total++; if (done_cnt !== nf) begin bad++; $display("FAIL rnd_done got=%0d want=%0d", done_cnt, nf); end
        total++; if (beat_count !== LEN_W'(lastlen)) begin bad++; $display("FAIL rnd_beat_count got=%0d want=%0d", beat_count, lastlen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy got=%b want=0", busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_words();
        test_padding();
        test_back_to_back();
        test_stall();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
